// File: rtl/mm2s_buf_wr_pkg.sv
// Shared definitions for the MM2S buffer writer: tag field layout, destination
// encodings, FSM states and error-flag bit positions.
package mm2s_buf_wr_pkg;

  localparam int DFLT_CORE_AXI_DATA_WIDTH = 64;
  localparam int DFLT_MEM_TAG_WIDTH       = 64;

  localparam int TAG_N_LSB = 16;
  localparam int TAG_N_MSB = 31;

  localparam int ERR_TLAST    = 0;
  localparam int ERR_DEST_MIS = 1;
  localparam int ERR_DEST_BAD = 2;

  typedef enum logic [1:0] {
    DEST_ACT  = 2'd0,
    DEST_WGT  = 2'd1,
    DEST_BIAS = 2'd2,
    DEST_NONE = 2'd3
  } dest_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Destination 3 has no buffer behind it, so it maps to an all-zero strobe.
  function automatic logic [2:0] dest_onehot(input logic [1:0] dest);
    logic [2:0] oh;
    oh = 3'b000;
    case (dest)
      DEST_ACT:  oh = 3'b001;
      DEST_WGT:  oh = 3'b010;
      DEST_BIAS: oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/mm2s_buf_wr.sv
// Writes tagged tile data beats from mm2s_ctrl into the act/wgt/bias on-chip
// buffers, pulses tile_done per tile and keeps a tile count plus sticky errors.
module mm2s_buf_wr
  import mm2s_buf_wr_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = DFLT_CORE_AXI_DATA_WIDTH,
  parameter int MM2S_TAG_WIDTH = DFLT_MEM_TAG_WIDTH,
  parameter int BUF_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_axis_mm2s_tag_tvalid,
  output logic                      s_axis_mm2s_tag_tready,
  input  logic [MM2S_TAG_WIDTH-1:0] s_axis_mm2s_tag_tdata,
  input  logic [1:0]                s_axis_mm2s_tag_tdest,
  input  logic                      s_axis_mm2s_tvalid,
  output logic                      s_axis_mm2s_tready,
  input  logic [AXI_DATA_WIDTH-1:0] s_axis_mm2s_tdata,
  input  logic                      s_axis_mm2s_tlast,
  input  logic [1:0]                s_axis_mm2s_tdest,
  output logic [2:0]                buf_wr_en,
  output logic [BUF_ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [AXI_DATA_WIDTH-1:0] buf_wr_data,
  output logic [2:0]                tile_done,
  output logic [1:0][31:0]          status
);

  state_e                    state, state_nxt;
  logic [BUF_ADDR_WIDTH-1:0] wr_ptr;
  logic [15:0]               beat_n, beat_k;
  logic [1:0]                dest_q;
  logic [2:0]                err_q;
  logic [31:0]               tile_cnt;

  logic                      tag_hs, data_hs, last_beat;
  logic [15:0]               tag_n;
  logic [BUF_ADDR_WIDTH-1:0] tag_base;
  logic [1:0]                done_dest;

  assign tag_hs    = s_axis_mm2s_tag_tvalid & s_axis_mm2s_tag_tready;
  assign data_hs   = s_axis_mm2s_tvalid & s_axis_mm2s_tready;
  assign tag_n     = s_axis_mm2s_tag_tdata[TAG_N_MSB:TAG_N_LSB];
  assign tag_base  = s_axis_mm2s_tag_tdata[BUF_ADDR_WIDTH-1:0];
  assign last_beat = (beat_k == beat_n - 16'd1);
  // A zero-beat tile reaches DONE straight from IDLE, before dest_q is loaded.
  assign done_dest = (state == ST_IDLE) ? s_axis_mm2s_tag_tdest : dest_q;

  assign status = {{29'd0, err_q}, tile_cnt};

  // NOTE: every state register uses non-blocking (<=) so all flops update
  // together on the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt is defaulted before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (tag_hs) state_nxt = (tag_n == 16'd0) ? ST_DONE : ST_XFER;
      ST_XFER: if (data_hs && last_beat) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Readies are registered from the next state so they never see tvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axis_mm2s_tag_tready <= 1'b0;
      s_axis_mm2s_tready     <= 1'b0;
    end else begin
      s_axis_mm2s_tag_tready <= (state_nxt == ST_IDLE);
      s_axis_mm2s_tready     <= (state_nxt == ST_XFER);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      beat_n      <= '0;
      beat_k      <= '0;
      dest_q      <= '0;
      err_q       <= '0;
      tile_cnt    <= '0;
      buf_wr_en   <= '0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      tile_done   <= '0;
    end else begin
      buf_wr_en <= '0;
      tile_done <= '0;

      if (tag_hs) begin
        wr_ptr <= tag_base;
        beat_n <= tag_n;
        beat_k <= '0;
        dest_q <= s_axis_mm2s_tag_tdest;
        if (s_axis_mm2s_tag_tdest == DEST_NONE) err_q[ERR_DEST_BAD] <= 1'b1;
      end

      if (data_hs) begin
        buf_wr_en   <= dest_onehot(dest_q);
        buf_wr_addr <= wr_ptr;
        buf_wr_data <= s_axis_mm2s_tdata;
        wr_ptr      <= wr_ptr + 1'b1;
        beat_k      <= beat_k + 16'd1;
        if (s_axis_mm2s_tlast != last_beat)  err_q[ERR_TLAST]    <= 1'b1;
        if (s_axis_mm2s_tdest != dest_q)     err_q[ERR_DEST_MIS] <= 1'b1;
      end

      // tile_done and the count land in the same cycle the FSM sits in DONE.
      if (state_nxt == ST_DONE) begin
        tile_done <= dest_onehot(done_dest);
        tile_cnt  <= tile_cnt + 32'd1;
      end
    end
  end

endmodule
